// File: rtl/axi_riscv_atomics_pkg.sv
// Shared atomics-adapter package: debug op encoding and sizing helpers
// used by the reservation table.
package axi_riscv_atomics_pkg;

    typedef enum logic [2:0] {
        RSV_LR,
        RSV_SC_PASS,
        RSV_SC_FAIL,
        RSV_SNOOP,
        RSV_TIMEOUT
    } rsv_op_e;

    // Age counter only has to reach timeout-1 before the entry is dropped.
    function automatic int unsigned rsv_age_width(input int unsigned timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/axi_riscv_rsv_table_lzc.sv
// Trailing-zero counter: index of the lowest set bit, empty_o when none set.
module axi_riscv_rsv_table_lzc #(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             empty_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) cnt_o = CNT_W'(i);
        end
        empty_o = ~|in_i;
    end

endmodule

// File: rtl/axi_riscv_rsv_table.sv
// Multi-entry LR/SC reservation table: one reservation per requester ID with
// timeout, round-robin eviction, write-snoop invalidation and a registered SC verdict.
module axi_riscv_rsv_table
    import axi_riscv_atomics_pkg::*;
#(
    parameter int unsigned NUM_RSV        = 4,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned ADDR_LSB       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_WIDTH      = $clog2(NUM_RSV + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  lr_valid_i,
    output logic                  lr_ready_o,
    input  logic [ID_WIDTH-1:0]   lr_id_i,
    input  logic [ADDR_WIDTH-1:0] lr_addr_i,
    input  logic                  sc_valid_i,
    output logic                  sc_ready_o,
    input  logic [ID_WIDTH-1:0]   sc_id_i,
    input  logic [ADDR_WIDTH-1:0] sc_addr_i,
    output logic                  sc_resp_valid_o,
    input  logic                  sc_resp_ready_i,
    output logic                  sc_pass_o,
    input  logic                  wr_valid_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic                  flush_i,
    output logic [CNT_WIDTH-1:0]  rsv_count_o
);

    localparam int unsigned TAG_W = ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned IDX_W = (NUM_RSV > 1) ? $clog2(NUM_RSV) : 1;
    localparam int unsigned AGE_W = rsv_age_width(TIMEOUT_CYCLES);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] id;
        logic [TAG_W-1:0]    tag;
        logic [AGE_W-1:0]    age;
    } entry_t;

    entry_t [NUM_RSV-1:0] rsv_q, rsv_d;
    logic [IDX_W-1:0]     victim_q, victim_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 pass_q, pass_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    logic             lr_fire, sc_fire, sc_pass, table_full;
    logic [TAG_W-1:0] lr_tag, sc_tag, wr_tag;
    logic [NUM_RSV-1:0] sc_hit, keep, id_hit;
    logic [IDX_W-1:0] free_idx, id_idx, tgt_idx;

    assign lr_ready_o      = ~resp_valid_q;
    assign sc_ready_o      = ~resp_valid_q;
    assign lr_fire         = lr_valid_i & ~resp_valid_q;
    assign sc_fire         = sc_valid_i & ~resp_valid_q;
    assign sc_resp_valid_o = resp_valid_q;
    assign sc_pass_o       = pass_q;
    assign rsv_count_o     = count_q;

    assign lr_tag = lr_addr_i[ADDR_WIDTH-1:ADDR_LSB];
    assign sc_tag = sc_addr_i[ADDR_WIDTH-1:ADDR_LSB];
    assign wr_tag = wr_addr_i[ADDR_WIDTH-1:ADDR_LSB];

    if (ADDR_LSB > 0) begin : g_lsb
        logic unused_lsbs;
        assign unused_lsbs = ^{lr_addr_i[ADDR_LSB-1:0], sc_addr_i[ADDR_LSB-1:0], wr_addr_i[ADDR_LSB-1:0]};
    end

    // All clears look at the pre-edge table; the LR install is applied on top of the survivors.
    for (genvar gi = 0; gi < NUM_RSV; gi++) begin : g_entry
        logic sc_id_hit, sc_tag_hit, kill;
        assign sc_id_hit  = rsv_q[gi].valid && (rsv_q[gi].id == sc_id_i);
        assign sc_tag_hit = rsv_q[gi].valid && (rsv_q[gi].tag == sc_tag);
        assign sc_hit[gi] = sc_id_hit && sc_tag_hit;
        assign kill = flush_i
                   || ((TIMEOUT_CYCLES != 0) && (rsv_q[gi].age == AGE_LAST))
                   || (wr_valid_i && (rsv_q[gi].tag == wr_tag))
                   || (sc_fire && (sc_id_hit || (sc_pass && sc_tag_hit)));
        assign keep[gi]   = rsv_q[gi].valid && !kill;
        assign id_hit[gi] = keep[gi] && (rsv_q[gi].id == lr_id_i);
    end

    assign sc_pass = |sc_hit;

    axi_riscv_rsv_table_lzc #(
        .WIDTH (NUM_RSV)
    ) i_free_lzc (
        .in_i    (~keep),
        .cnt_o   (free_idx),
        .empty_o (table_full)
    );

    always_comb begin
        id_idx = '0;
        for (int i = 0; i < NUM_RSV; i++) begin
            if (id_hit[i]) id_idx = IDX_W'(i);
        end
    end

    always_comb begin
        rsv_d    = rsv_q;
        victim_d = victim_q;
        tgt_idx  = victim_q;
        for (int i = 0; i < NUM_RSV; i++) begin
            rsv_d[i].valid = keep[i];
            if ((TIMEOUT_CYCLES != 0) && keep[i] && (rsv_q[i].age != '1))
                rsv_d[i].age = rsv_q[i].age + 1'b1;
        end
        if (lr_fire && !flush_i) begin
            if (|id_hit) begin
                tgt_idx = id_idx;
            end else if (!table_full) begin
                tgt_idx = free_idx;
            end else begin
                victim_d = (victim_q == IDX_W'(NUM_RSV - 1)) ? '0 : victim_q + 1'b1;
            end
            rsv_d[tgt_idx] = '{valid: 1'b1, id: lr_id_i, tag: lr_tag, age: '0};
        end
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        pass_d       = pass_q;
        if (sc_fire) begin
            resp_valid_d = 1'b1;
            pass_d       = sc_pass;
        end else if (resp_valid_q && sc_resp_ready_i) begin
            resp_valid_d = 1'b0;
        end
        count_d = '0;
        for (int i = 0; i < NUM_RSV; i++) begin
            count_d = count_d + CNT_WIDTH'(rsv_d[i].valid);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsv_q        <= '0;
            victim_q     <= '0;
            resp_valid_q <= 1'b0;
            pass_q       <= 1'b0;
            count_q      <= '0;
        end else begin
            rsv_q        <= rsv_d;
            victim_q     <= victim_d;
            resp_valid_q <= resp_valid_d;
            pass_q       <= pass_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_axi_riscv_rsv_table.sv
// Bench for the LR/SC reservation table: directed scenarios plus a randomized
// run, all checked against a slot-level reference model of the table rules.
module tb_axi_riscv_rsv_table;

    localparam int NR  = 4;
    localparam int IDW = 4;
    localparam int AW  = 64;
    localparam int LSB = 3;
    localparam int TMO = 8;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lr_valid = 1'b0;
    logic          lr_ready;
    logic [IDW-1:0] lr_id = '0;
    logic [AW-1:0] lr_addr = '0;
    logic          sc_valid = 1'b0;
    logic          sc_ready;
    logic [IDW-1:0] sc_id = '0;
    logic [AW-1:0] sc_addr = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic          pass;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic          flush = 1'b0;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one slot per entry, expiry from install timestamp.
    bit              m_v[NR];
    int              m_id[NR];
    longint unsigned m_tag[NR];
    int              m_birth[NR];
    int              m_victim = 0;
    int              m_cyc = 0;
    int              m_cnt = 0;
    bit              m_rv = 1'b0;
    bit              m_pass = 1'b0;
    bit              m_sc_fired = 1'b0;

    axi_riscv_rsv_table #(
        .NUM_RSV        (NR),
        .ID_WIDTH       (IDW),
        .ADDR_WIDTH     (AW),
        .ADDR_LSB       (LSB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .lr_valid_i      (lr_valid),
        .lr_ready_o      (lr_ready),
        .lr_id_i         (lr_id),
        .lr_addr_i       (lr_addr),
        .sc_valid_i      (sc_valid),
        .sc_ready_o      (sc_ready),
        .sc_id_i         (sc_id),
        .sc_addr_i       (sc_addr),
        .sc_resp_valid_o (resp_valid),
        .sc_resp_ready_i (resp_ready),
        .sc_pass_o       (pass),
        .wr_valid_i      (wr_valid),
        .wr_addr_i       (wr_addr),
        .flush_i         (flush),
        .rsv_count_o     (count)
    );

    always #5 clk = ~clk;

    function automatic void model_step();
        bit lr_f, sc_f, ok;
        longint unsigned st, wt, lt;
        int slot;
        m_cyc++;
        m_sc_fired = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) m_v[i] = 1'b0;
            m_victim = 0; m_rv = 1'b0; m_pass = 1'b0; m_cnt = 0;
            return;
        end
        lr_f = lr_valid && !m_rv;
        sc_f = sc_valid && !m_rv;
        st = sc_addr >> LSB;
        wt = wr_addr >> LSB;
        lt = lr_addr >> LSB;
        ok = 1'b0;
        if (sc_f)
            for (int i = 0; i < NR; i++)
                if (m_v[i] && m_id[i] == int'(sc_id) && m_tag[i] == st) ok = 1'b1;
        for (int i = 0; i < NR; i++) begin
            if (flush) m_v[i] = 1'b0;
            if (m_cyc - m_birth[i] >= TMO) m_v[i] = 1'b0;
            if (wr_valid && m_tag[i] == wt) m_v[i] = 1'b0;
            if (sc_f && m_id[i] == int'(sc_id)) m_v[i] = 1'b0;
            if (sc_f && ok && m_tag[i] == st) m_v[i] = 1'b0;
        end
        if (lr_f && !flush) begin
            slot = -1;
            for (int i = 0; i < NR; i++) if (m_v[i] && m_id[i] == int'(lr_id)) slot = i;
            for (int i = 0; i < NR; i++) if (slot < 0 && !m_v[i]) slot = i;
            if (slot < 0) begin
                slot = m_victim;
                m_victim = (m_victim + 1) % NR;
            end
            m_v[slot] = 1'b1; m_id[slot] = int'(lr_id); m_tag[slot] = lt; m_birth[slot] = m_cyc;
        end
        if (sc_f) begin
            m_rv = 1'b1; m_pass = ok; m_sc_fired = 1'b1;
        end else if (m_rv && resp_ready) begin
            m_rv = 1'b0;
        end
        m_cnt = 0;
        for (int i = 0; i < NR; i++) m_cnt += int'(m_v[i]);
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic lr(input int id, input longint unsigned addr, input bit snoop, input bit fl);
        lr_valid = 1'b1; lr_id = IDW'(id); lr_addr = addr;
        wr_valid = snoop; wr_addr = addr; flush = fl;
        cycle();
        lr_valid = 1'b0; wr_valid = 1'b0; flush = 1'b0;
        $display("lr  id=%0d addr=%0h snoop=%0b flush=%0b count=%0d", id, addr, snoop, fl, count);
    endtask

    task automatic sc(input int id, input longint unsigned addr,
                      output bit got_v, output bit got_p, output bit exp_p);
        sc_valid = 1'b1; sc_id = IDW'(id); sc_addr = addr;
        cycle();
        sc_valid = 1'b0;
        got_v = resp_valid; got_p = pass; exp_p = m_pass;
        $display("sc  id=%0d addr=%0h valid=%0b pass=%0b", id, addr, got_v, got_p);
        resp_ready = 1'b1;
        cycle();
        resp_ready = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %0b want 0", resp_valid); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass: got %0b want 0", pass); end
        n_cmp++; if (lr_ready !== 1'b1 || sc_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b%0b want 11", lr_ready, sc_ready); end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_lr_sc_pass();
        bit gv, gp, ep;
        lr(1, 'h1000, 1'b0, 1'b0);
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL lr_count: got %0d want 1", count); end
        sc(1, 'h1004, gv, gp, ep);
        n_cmp++; if (gv !== 1'b1) begin n_bad++; $display("FAIL sc_resp_valid: got %0b want 1", gv); end
        n_cmp++; if (gp !== 1'b1) begin n_bad++; $display("FAIL sc_same_granule: got %0b want 1", gp); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL sc_count: got %0d want 0", count); end
    endtask

    task automatic test_snoop();
        bit gv, gp, ep;
        lr(2, 'h2000, 1'b0, 1'b0);
        wr_valid = 1'b1; wr_addr = 'h2000;
        cycle();
        wr_valid = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL snoop_count: got %0d want 0", count); end
        sc(2, 'h2000, gv, gp, ep);
        n_cmp++; if (gp !== 1'b0) begin n_bad++; $display("FAIL snoop_sc1: got %0b want 0", gp); end
        sc(2, 'h2000, gv, gp, ep);
        n_cmp++; if (gp !== 1'b0) begin n_bad++; $display("FAIL snoop_sc2: got %0b want 0", gp); end
    endtask

    task automatic test_eviction();
        bit gv, gp, ep;
        for (int i = 0; i < 5; i++) lr(i, longint'(i + 1) << 8, 1'b0, 1'b0);
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL evict_count: got %0d want 4", count); end
        n_cmp++; if (m_victim != 1) begin n_bad++; $display("FAIL evict_ptr_model: got %0d want 1", m_victim); end
        sc(0, 'h100, gv, gp, ep);
        n_cmp++; if (gp !== 1'b0) begin n_bad++; $display("FAIL evicted_sc: got %0b want 0", gp); end
        sc(4, 'h500, gv, gp, ep);
        n_cmp++; if (gp !== 1'b1) begin n_bad++; $display("FAIL newest_sc: got %0b want 1", gp); end
        n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL evict_after_count: got %0d want 3", count); end
    endtask

    task automatic test_cross_kill();
        bit gv, gp, ep;
        do_flush();
        lr(3, 'h40, 1'b0, 1'b0);
        lr(5, 'h40, 1'b0, 1'b0);
        sc(3, 'h40, gv, gp, ep);
        n_cmp++; if (gp !== 1'b1) begin n_bad++; $display("FAIL xkill_sc3: got %0b want 1", gp); end
        sc(5, 'h40, gv, gp, ep);
        n_cmp++; if (gp !== 1'b0) begin n_bad++; $display("FAIL xkill_sc5: got %0b want 0", gp); end
    endtask

    task automatic test_timeout();
        bit gv, gp, ep;
        do_flush();
        lr(1, 'h1000, 1'b0, 1'b0);
        idle(7);
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL tmo_last_cycle: got %0d want 1", count); end
        idle(1);
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL tmo_expired: got %0d want 0", count); end
        sc(1, 'h1000, gv, gp, ep);
        n_cmp++; if (gp !== 1'b0) begin n_bad++; $display("FAIL tmo_sc_late: got %0b want 0", gp); end
        lr(1, 'h1000, 1'b0, 1'b0);
        idle(6);
        sc(1, 'h1000, gv, gp, ep);
        n_cmp++; if (gp !== 1'b1) begin n_bad++; $display("FAIL tmo_sc_early: got %0b want 1", gp); end
    endtask

    task automatic test_same_cycle();
        bit gv, gp, ep;
        do_flush();
        lr(1, 'h3000, 1'b1, 1'b0);
        sc(1, 'h3000, gv, gp, ep);
        n_cmp++; if (gp !== 1'b1) begin n_bad++; $display("FAIL lr_snoop_sc: got %0b want 1", gp); end
        lr(2, 'h3100, 1'b0, 1'b1);
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL lr_flush_count: got %0d want 0", count); end
        lr(6, 'h500, 1'b0, 1'b0);
        lr_valid = 1'b1; lr_id = 4'd6; lr_addr = 'h600;
        sc_valid = 1'b1; sc_id = 4'd6; sc_addr = 'h500;
        cycle();
        lr_valid = 1'b0; sc_valid = 1'b0;
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL lr_sc_same_id_old: got %0b want 1", pass); end
        n_cmp++; if (lr_ready !== 1'b0) begin n_bad++; $display("FAIL ready_while_pending: got %0b want 0", lr_ready); end
        resp_ready = 1'b1;
        cycle();
        resp_ready = 1'b0;
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL lr_sc_same_id_count: got %0d want 1", count); end
        sc(6, 'h600, gv, gp, ep);
        n_cmp++; if (gp !== 1'b1) begin n_bad++; $display("FAIL lr_sc_same_id_new: got %0b want 1", gp); end
    endtask

    task automatic test_reset_mid();
        lr(1, 'h1000, 1'b0, 1'b0);
        lr(2, 'h2000, 1'b0, 1'b0);
        sc_valid = 1'b1; sc_id = 4'd1; sc_addr = 'h1000;
        cycle();
        sc_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_resp_valid: got %0b want 0", resp_valid); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL midrst_count: got %0d want 0", count); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL midrst_pass: got %0b want 0", pass); end
    endtask

    task automatic test_back_to_back();
        longint unsigned addrs [5];
        addrs[0] = 'h40; addrs[1] = 'h1000; addrs[2] = 'h1008; addrs[3] = 'h2000; addrs[4] = 'h3000;
        for (int n = 0; n < 400; n++) begin
            lr_valid   = ($urandom_range(0, 9) < 4);
            lr_id      = IDW'($urandom_range(0, 5));
            lr_addr    = addrs[$urandom_range(0, 4)] + longint'($urandom_range(0, 7));
            sc_valid   = ($urandom_range(0, 9) < 3);
            sc_id      = IDW'($urandom_range(0, 5));
            sc_addr    = addrs[$urandom_range(0, 4)] + longint'($urandom_range(0, 7));
            resp_ready = ($urandom_range(0, 1) == 1);
            wr_valid   = ($urandom_range(0, 19) < 3);
            wr_addr    = addrs[$urandom_range(0, 4)] + longint'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 49) == 0);
            cycle();
            if (m_sc_fired) $display("rnd sc id=%0d addr=%0h pass=%0b", sc_id, sc_addr, pass);
            n_cmp++; if (count !== CW'(m_cnt)) begin n_bad++; $display("FAIL rnd_count n=%0d: got %0d want %0d", n, count, m_cnt); end
            n_cmp++; if (resp_valid !== m_rv) begin n_bad++; $display("FAIL rnd_resp_valid n=%0d: got %0b want %0b", n, resp_valid, m_rv); end
            n_cmp++; if (lr_ready !== !m_rv) begin n_bad++; $display("FAIL rnd_ready n=%0d: got %0b want %0b", n, lr_ready, !m_rv); end
            if (m_rv) begin
                n_cmp++; if (pass !== m_pass) begin n_bad++; $display("FAIL rnd_pass n=%0d: got %0b want %0b", n, pass, m_pass); end
            end
        end
        lr_valid = 1'b0; sc_valid = 1'b0; resp_ready = 1'b0; wr_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lr_sc_pass();
        test_snoop();
        test_eviction();
        test_cross_kill();
        test_timeout();
        test_same_cycle();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
